// File: rtl/sim_bus_arbiter_if.sv
// Bus bundle between NumHosts hosts, the shared simulator-device port and the arbiter.
// The slave modport is the arbiter's view; master is the hosts/device environment view.
interface sim_bus_arbiter_if #(
   parameter int unsigned NumHosts = 2
);
   logic [NumHosts-1:0]    host_req_i;
   logic [NumHosts-1:0]    host_we_i;
   logic [4*NumHosts-1:0]  host_be_i;
   logic [32*NumHosts-1:0] host_addr_i;
   logic [32*NumHosts-1:0] host_wdata_i;
   logic [NumHosts-1:0]    host_gnt_o;
   logic [NumHosts-1:0]    host_rvalid_o;
   logic [32*NumHosts-1:0] host_rdata_o;

   logic                   dev_req_o;
   logic                   dev_we_o;
   logic [3:0]             dev_be_o;
   logic [31:0]            dev_addr_o;
   logic [31:0]            dev_wdata_o;
   logic                   dev_rvalid_i;
   logic [31:0]            dev_rdata_i;

   modport slave (
      input  host_req_i, host_we_i, host_be_i, host_addr_i, host_wdata_i,
      input  dev_rvalid_i, dev_rdata_i,
      output host_gnt_o, host_rvalid_o, host_rdata_o,
      output dev_req_o, dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o
   );

   modport master (
      output host_req_i, host_we_i, host_be_i, host_addr_i, host_wdata_i,
      output dev_rvalid_i, dev_rdata_i,
      input  host_gnt_o, host_rvalid_o, host_rdata_o,
      input  dev_req_o, dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o
   );
endinterface

// File: rtl/sim_bus_arbiter.sv
// Round-robin arbiter sharing one grantless, fixed-latency simulator device among NumHosts hosts.
// An owner FIFO routes in-order responses back to the issuing host; orphan responses raise a sticky error.
module sim_bus_arbiter #(
   parameter int unsigned NumHosts       = 2,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   sim_bus_arbiter_if.slave    bus,
   output logic                err_unexp_rvalid_o
);

   localparam int unsigned IdxW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   localparam logic [PtrW-1:0] LastSlot = PtrW'(MaxOutstanding - 1);
   localparam logic [CntW-1:0] FullCnt  = CntW'(MaxOutstanding);

   logic [IdxW-1:0] rr_q, rr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [PtrW-1:0] wptr_q, wptr_d;
   logic [PtrW-1:0] rptr_q, rptr_d;
   logic [IdxW-1:0] owner_q [MaxOutstanding];
   logic [IdxW-1:0] owner_d [MaxOutstanding];
   logic            err_q, err_d;

   logic                can_issue_c;
   logic                grant_c;
   logic [IdxW-1:0]     win_c;
   logic [NumHosts-1:0] gnt_c;
   logic                push_c;
   logic                pop_c;
   logic [NumHosts-1:0] rvalid_c;
   logic                dev_we_c;
   logic [3:0]          dev_be_c;
   logic [31:0]         dev_addr_c;
   logic [31:0]         dev_wdata_c;

   // Host index base+off modulo NumHosts, for any (non power-of-two) host count.
   function automatic logic [IdxW-1:0] host_add(input logic [IdxW-1:0] base, input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= NumHosts) s = s - NumHosts;
      return IdxW'(s);
   endfunction

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastSlot) ? '0 : p + PtrW'(1);
   endfunction

   // Winner search starts at rr_q; a full FIFO blocks issue even if it pops this cycle.
   always_comb begin
      logic [IdxW-1:0] idx;
      can_issue_c = (cnt_q < FullCnt);
      grant_c     = 1'b0;
      win_c       = '0;
      idx         = '0;
      for (int unsigned k = 0; k < NumHosts; k++) begin
         idx = host_add(rr_q, k);
         if (can_issue_c && !grant_c && bus.host_req_i[idx]) begin
            grant_c = 1'b1;
            win_c   = idx;
         end
      end
      gnt_c = '0;
      if (grant_c) gnt_c[win_c] = 1'b1;
   end

   // Request fields are taken straight from the winning host; idle bus is driven to zero.
   always_comb begin
      dev_we_c    = 1'b0;
      dev_be_c    = '0;
      dev_addr_c  = '0;
      dev_wdata_c = '0;
      if (grant_c) begin
         dev_we_c    = bus.host_we_i[win_c];
         dev_be_c    = bus.host_be_i[32'(win_c)*4 +: 4];
         dev_addr_c  = bus.host_addr_i[32'(win_c)*32 +: 32];
         dev_wdata_c = bus.host_wdata_i[32'(win_c)*32 +: 32];
      end
   end

   // Response routing to the FIFO head owner; orphan responses are dropped.
   always_comb begin
      push_c   = grant_c;
      pop_c    = bus.dev_rvalid_i && (cnt_q != '0);
      rvalid_c = '0;
      if (pop_c) rvalid_c[owner_q[rptr_q]] = 1'b1;
   end

   // Next-state for round-robin pointer, owner FIFO and sticky error.
   always_comb begin
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      owner_d = owner_q;
      err_d   = err_q;

      if (grant_c) rr_d = host_add(win_c, 1);

      if (push_c) begin
         owner_d[wptr_q] = win_c;
         wptr_d          = ptr_inc(wptr_q);
      end
      if (pop_c) rptr_d = ptr_inc(rptr_q);

      unique case ({push_c, pop_c})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase

      if (bus.dev_rvalid_i && (cnt_q == '0)) err_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q   <= '0;
         cnt_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         err_q  <= 1'b0;
         for (int unsigned i = 0; i < MaxOutstanding; i++) owner_q[i] <= '0;
      end else begin
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         err_q   <= err_d;
         owner_q <= owner_d;
      end
   end

   assign bus.host_gnt_o    = gnt_c;
   assign bus.host_rvalid_o = rvalid_c;
   assign bus.host_rdata_o  = {NumHosts{bus.dev_rdata_i}};
   assign bus.dev_req_o     = grant_c;
   assign bus.dev_we_o      = dev_we_c;
   assign bus.dev_be_o      = dev_be_c;
   assign bus.dev_addr_o    = dev_addr_c;
   assign bus.dev_wdata_o   = dev_wdata_c;
   assign err_unexp_rvalid_o = err_q;

   // Structural invariants.
   a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_c));
   a_cnt_bound  : assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= FullCnt);
   a_no_full_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni) (cnt_q == FullCnt) |-> !grant_c);

endmodule
